// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet codes, line-fill engine states and header packing.
// Destination coordinates fall back to tile (0,0) when the build does not define them.
`ifndef X_DRAM
`define X_DRAM 3'd0
`endif
`ifndef Y_DRAM
`define Y_DRAM 3'd0
`endif

package noc_pkg;

    localparam logic [3:0] MLOAD  = 4'd2;
    localparam logic [3:0] MSTORE = 4'd3;
    localparam logic [3:0] MPUT   = 4'd4;
    localparam logic [3:0] MGET   = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_SRC,
        ST_DATA,
        ST_WAIT_FILL
    } lfe_state_t;

    function automatic logic [31:0] noc_hdr(
        input logic [3:0] code,
        input logic [2:0] sz,
        input logic [5:0] src,
        input logic [2:0] y,
        input logic [2:0] x
    );
        return {3'b000, 1'b1, code, 1'b0, src, 2'b00, 4'b0100, sz, 2'b00, y, x};
    endfunction

endpackage

// File: rtl/noc_line_collect.sv
// Refill line assembly: per-word registers, arrival mask and full detection.
// Words land in any order; a repeated word overwrites its data without touching the mask.
module noc_line_collect
    import noc_pkg::*;
#(
    parameter int WORDS_PER_LINE = 16
) (
    input  logic                            clk_ctrl,
    input  logic                            clk_ctrl_rst_high,
    input  logic                            clr,
    input  logic                            wr_en,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_idx,
    input  logic [31:0]                     wr_data,
    output logic [32*WORDS_PER_LINE-1:0]    line,
    output logic                            full,
    output logic                            completes
);

    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    logic [WORDS_PER_LINE-1:0] mask_reg;
    logic [WORDS_PER_LINE-1:0] mask_next;
    logic [WORDS_PER_LINE-1:0] wr_bit;

    assign wr_bit    = wr_en ? (WORDS_PER_LINE'(1) << wr_idx) : '0;
    assign full      = &mask_reg;
    assign completes = wr_en && (&(mask_reg | wr_bit)) && !full;

    // A clear that coincides with a write keeps that write's bit.
    always_comb begin
        mask_next = mask_reg | wr_bit;
        if (clr) begin
            mask_next = wr_bit;
        end
    end

    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst_high) begin
        if (clk_ctrl_rst_high) begin
            mask_reg <= '0;
        end else begin
            mask_reg <= mask_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            logic [31:0] word_reg;
            always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst_high) begin
                if (clk_ctrl_rst_high) begin
                    word_reg <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    word_reg <= wr_data;
                end
            end
            assign line[32*gi +: 32] = word_reg;
        end
    endgenerate

endmodule

// File: rtl/noc_line_fill_engine.sv
// Cache-line transfer engine: emits MGET/MPUT packets on a 32-bit stream and
// collects refill words from the NoC write port, re-issuing a refill that times out.
`ifndef X_DRAM
`define X_DRAM 3'd0
`endif
`ifndef Y_DRAM
`define Y_DRAM 3'd0
`endif

module noc_line_fill_engine
    import noc_pkg::*;
#(
    parameter int          WORDS_PER_LINE = 16,
    parameter logic [31:0] LOCAL_BASE_W   = 32'h1000,
    parameter logic [2:0]  X_DRAM         = `X_DRAM,
    parameter logic [2:0]  Y_DRAM         = `Y_DRAM,
    parameter int          TIMEOUT_CYC    = 4096
) (
    input  logic                          clk_ctrl,
    input  logic                          clk_ctrl_rst_high,
    input  logic [5:0]                    HsrcId,
    input  logic [31:0]                   mem_req_addr,
    input  logic [32*WORDS_PER_LINE-1:0]  mem_req_data,
    input  logic                          mem_req_rw,
    input  logic                          mem_req_valid,
    output logic                          mem_req_ready,
    output logic [32*WORDS_PER_LINE-1:0]  mem_data_data,
    output logic                          mem_data_ready,
    input  logic                          stream_out_TREADY,
    output logic                          stream_out_TVALID,
    output logic [31:0]                   stream_out_TDATA,
    output logic [3:0]                    stream_out_TKEEP,
    output logic                          stream_out_TLAST,
    input  logic [31:0]                   mem_addr,
    input  logic [31:0]                   mem_wdata,
    input  logic                          mem_wstrb,
    input  logic                          mem_valid,
    output logic                          stray_wr,
    output logic                          fill_timeout
);

    localparam int          LINE_W   = 32 * WORDS_PER_LINE;
    localparam int          IDX_W    = $clog2(WORDS_PER_LINE);
    localparam int          CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [31:0] OFF_MASK = 32'(4 * WORDS_PER_LINE - 1);
    localparam logic [2:0]  WB_SZ    = 3'(WORDS_PER_LINE / 4);

    lfe_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  beat_reg, beat_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       addr_reg;
    logic              rw_reg;
    logic [LINE_W-1:0] data_reg;
    logic [5:0]        src_reg;
    logic              stray_reg;

    logic              in_wr;
    logic              col_wr;
    logic              col_clr;
    logic              col_full;
    logic              col_completes;
    logic              timeout_hit;
    logic              last_beat;
    logic [31:0]       data_word;
    logic              unused_addr_bits;

    assign in_wr            = mem_valid && mem_wstrb;
    assign col_wr           = in_wr && (state_reg == ST_WAIT_FILL);
    assign data_word        = data_reg[{beat_reg, 5'd0} +: 32];
    assign mem_req_ready    = (state_reg == ST_IDLE);
    assign stray_wr         = stray_reg;
    assign unused_addr_bits = ^mem_addr[31:IDX_W];

    // A write that completes the line in the timeout cycle suppresses the re-issue.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (state_reg == ST_WAIT_FILL)
                         && (cnt_reg == CNT_W'(TIMEOUT_CYC)) && !col_full && !col_completes;

    always_comb begin
        state_next        = state_reg;
        beat_next         = beat_reg;
        cnt_next          = cnt_reg;
        col_clr           = 1'b0;
        last_beat         = 1'b0;
        mem_data_ready    = 1'b0;
        fill_timeout      = 1'b0;
        stream_out_TVALID = 1'b0;
        stream_out_TDATA  = 32'h0;
        stream_out_TLAST  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_req_valid) begin
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = noc_hdr(rw_reg ? MPUT : MGET, rw_reg ? WB_SZ : 3'd1,
                                            src_reg, Y_DRAM, X_DRAM);
                if (stream_out_TREADY) begin
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = addr_reg;
                if (stream_out_TREADY) begin
                    state_next = ST_SRC;
                end
            end
            ST_SRC: begin
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = (addr_reg >> 2) + LOCAL_BASE_W;
                if (stream_out_TREADY) begin
                    state_next = ST_DATA;
                    beat_next  = '0;
                end
            end
            ST_DATA: begin
                last_beat         = !rw_reg || (beat_reg == IDX_W'(WORDS_PER_LINE - 1));
                stream_out_TVALID = 1'b1;
                stream_out_TDATA  = rw_reg ? data_word : 32'h0;
                stream_out_TLAST  = last_beat;
                if (stream_out_TREADY) begin
                    if (!last_beat) begin
                        beat_next = beat_reg + 1'b1;
                    end else if (rw_reg) begin
                        mem_data_ready = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        col_clr    = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_WAIT_FILL;
                    end
                end
            end
            ST_WAIT_FILL: begin
                if (col_full) begin
                    mem_data_ready = 1'b1;
                    state_next     = ST_IDLE;
                end else if (timeout_hit) begin
                    fill_timeout = 1'b1;
                    col_clr      = 1'b1;
                    state_next   = ST_HDR;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        stream_out_TKEEP = stream_out_TVALID ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk_ctrl or posedge clk_ctrl_rst_high) begin
        if (clk_ctrl_rst_high) begin
            state_reg <= ST_IDLE;
            beat_reg  <= '0;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            rw_reg    <= 1'b0;
            data_reg  <= '0;
            src_reg   <= '0;
            stray_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            cnt_reg   <= cnt_next;
            stray_reg <= in_wr && (state_reg != ST_WAIT_FILL);
            if (mem_req_valid && (state_reg == ST_IDLE)) begin
                addr_reg <= mem_req_addr & ~OFF_MASK;
                rw_reg   <= mem_req_rw;
                data_reg <= mem_req_data;
                src_reg  <= HsrcId;
            end
        end
    end

    noc_line_collect #(
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_collect (
        .clk_ctrl          (clk_ctrl),
        .clk_ctrl_rst_high (clk_ctrl_rst_high),
        .clr               (col_clr),
        .wr_en             (col_wr),
        .wr_idx            (mem_addr[IDX_W-1:0]),
        .wr_data           (mem_wdata),
        .line              (mem_data_data),
        .full              (col_full),
        .completes         (col_completes)
    );

endmodule

// File: tb/tb_noc_line_fill_engine.sv
// Randomised bench for noc_line_fill_engine: packets and refill lines are predicted
// from the packet format and fill rules, then compared beat by beat and word by word.
`timescale 1ns/1ps
module tb_noc_line_fill_engine;

    localparam int          W      = 8;
    localparam int          LINE_W = 32 * W;
    localparam int          TMO    = 32;
    localparam logic [31:0] BASE   = 32'h1000;
    localparam logic [2:0]  XD     = 3'd5;
    localparam logic [2:0]  YD     = 3'd2;
    localparam logic [5:0]  SRC_ID = 6'h2B;

    logic              clk_ctrl = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       mem_req_addr = '0;
    logic [LINE_W-1:0] mem_req_data = '0;
    logic              mem_req_rw = 1'b0;
    logic              mem_req_valid = 1'b0;
    logic              mem_req_ready;
    logic [LINE_W-1:0] mem_data_data;
    logic              mem_data_ready;
    logic              tready = 1'b1;
    logic              tvalid;
    logic [31:0]       tdata;
    logic [3:0]        tkeep;
    logic              tlast;
    logic [31:0]       mem_addr = '0;
    logic [31:0]       mem_wdata = '0;
    logic              mem_wstrb = 1'b0;
    logic              mem_valid = 1'b0;
    logic              stray_wr;
    logic              fill_timeout;

    always #5 clk_ctrl = ~clk_ctrl;

    noc_line_fill_engine #(
        .WORDS_PER_LINE(W), .LOCAL_BASE_W(BASE), .X_DRAM(XD), .Y_DRAM(YD), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_ctrl(clk_ctrl), .clk_ctrl_rst_high(rst), .HsrcId(SRC_ID),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_rw(mem_req_rw),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_data_data(mem_data_data), .mem_data_ready(mem_data_ready),
        .stream_out_TREADY(tready), .stream_out_TVALID(tvalid), .stream_out_TDATA(tdata),
        .stream_out_TKEEP(tkeep), .stream_out_TLAST(tlast),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_valid(mem_valid),
        .stray_wr(stray_wr), .fill_timeout(fill_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: records accepted beats and checks hold-while-stalled.
    logic [31:0] got_data_q[$];
    logic        got_last_q[$];
    logic        got_mdr_q[$];
    int          stray_cnt = 0, tmo_cnt = 0, mdr_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk_ctrl) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", tvalid, 1'b1);
                check_eq("hold_data", tdata, prev_data);
                check_eq("hold_last", tlast, prev_last);
            end
            if (tvalid) check_eq("tkeep", tkeep, 4'hF);
            if (tvalid && tready) begin
                got_data_q.push_back(tdata);
                got_last_q.push_back(tlast);
                got_mdr_q.push_back(mem_data_ready);
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            if (stray_wr) stray_cnt++;
            if (fill_timeout) tmo_cnt++;
            if (mem_data_ready) mdr_cnt++;
        end
    end

    int tr_mode = 0;  // 0: always ready, 1: toggle, 2: random
    always @(posedge clk_ctrl) begin
        #1;
        case (tr_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model
    logic [31:0] exp_q[$];
    logic        exp_wb;
    logic [31:0] model_line [W];

    function automatic logic [31:0] hdr_word(input bit wb);
        int code = wb ? 4 : 5;
        int sz   = wb ? W / 4 : 1;
        return 32'((1 << 28) | (code << 24) | (int'(SRC_ID) << 17) | (4 << 11) | (sz << 8)
                   | (int'(YD) << 3) | int'(XD));
    endfunction

    task automatic build_exp(input logic [31:0] addr, input bit wb, input logic [LINE_W-1:0] line);
        logic [31:0] a;
        a = addr & ~32'(4 * W - 1);
        exp_wb = wb;
        exp_q.delete();
        exp_q.push_back(hdr_word(wb));
        exp_q.push_back(a);
        exp_q.push_back((a >> 2) + BASE);
        if (wb) for (int i = 0; i < W; i++) exp_q.push_back(line[32*i +: 32]);
        else exp_q.push_back(32'h0);
    endtask

    task automatic clear_got();
        got_data_q.delete(); got_last_q.delete(); got_mdr_q.delete();
    endtask

    task automatic send_req(input logic [31:0] addr, input bit wb, input logic [LINE_W-1:0] line);
        int n = 0;
        @(posedge clk_ctrl); #1;
        while (!mem_req_ready && n < 200) begin
            @(posedge clk_ctrl); #1; n++;
        end
        check_eq("req_ready", mem_req_ready, 1'b1);
        mem_req_addr = addr; mem_req_rw = wb; mem_req_data = line; mem_req_valid = 1'b1;
        @(posedge clk_ctrl); #1;
        mem_req_valid = 1'b0;
        check_eq("first_beat_latency", tvalid, 1'b1);
    endtask

    task automatic collect_packet(input string tag);
        int n = 0;
        int m;
        while (got_data_q.size() < exp_q.size() && n < 400) begin
            @(negedge clk_ctrl); #1; n++;
        end
        check_eq({tag, "_beats"}, got_data_q.size(), exp_q.size());
        m = (got_data_q.size() < exp_q.size()) ? got_data_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), got_data_q[i], exp_q[i]);
            check_eq($sformatf("%s_last%0d", tag, i), got_last_q[i], i == exp_q.size() - 1);
            check_eq($sformatf("%s_mdr%0d", tag, i), got_mdr_q[i],
                     exp_wb && (i == exp_q.size() - 1));
        end
    endtask

    task automatic run_packet(input logic [31:0] addr, input bit wb, input logic [LINE_W-1:0] line,
                              input string tag);
        clear_got();
        build_exp(addr, wb, line);
        send_req(addr, wb, line);
        collect_packet(tag);
    endtask

    task automatic check_line(input string tag);
        for (int i = 0; i < W; i++)
            check_eq($sformatf("%s_w%0d", tag, i), mem_data_data[32*i +: 32], model_line[i]);
    endtask

    // Response stimulus: the final entry is always the one that completes the line.
    int          r_idx[$];
    logic [31:0] r_dat[$];
    bit          r_stb[$];

    task automatic respond(input string tag);
        int s0 = stray_cnt;
        int t0 = tmo_cnt;
        int d0 = mdr_cnt;
        for (int i = 0; i < r_idx.size(); i++) begin
            @(posedge clk_ctrl); #1;
            if (i > 0) check_eq($sformatf("%s_early_done%0d", tag, i), mem_data_ready, 1'b0);
            mem_valid = 1'b1; mem_wstrb = r_stb[i]; mem_wdata = r_dat[i];
            mem_addr  = ($urandom & ~32'(W - 1)) | 32'(r_idx[i]);
            if (r_stb[i]) model_line[r_idx[i]] = r_dat[i];
        end
        @(posedge clk_ctrl); #1;
        mem_valid = 1'b0; mem_wstrb = 1'b0;
        check_eq({tag, "_done"}, mem_data_ready, 1'b1);
        check_eq({tag, "_busy"}, mem_req_ready, 1'b0);
        @(posedge clk_ctrl); #1;
        check_eq({tag, "_done_end"}, mem_data_ready, 1'b0);
        check_eq({tag, "_idle"}, mem_req_ready, 1'b1);
        check_eq({tag, "_pulses"}, mdr_cnt - d0, 1);
        check_eq({tag, "_no_stray"}, stray_cnt - s0, 0);
        check_eq({tag, "_no_tmo"}, tmo_cnt - t0, 0);
        check_line(tag);
        r_idx.delete(); r_dat.delete(); r_stb.delete();
    endtask

    task automatic push_resp(input int idx, input logic [31:0] dat, input bit stb);
        r_idx.push_back(idx); r_dat.push_back(dat); r_stb.push_back(stb);
    endtask

    task automatic push_random_order();
        int perm [W];
        for (int i = 0; i < W; i++) perm[i] = i;
        for (int i = W - 1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = perm[i];
            perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < W; i++) push_resp(perm[i], $urandom, 1'b1);
    endtask

    function automatic logic [LINE_W-1:0] random_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < W; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LINE_W-1:0] wl;
        int hit;
        int t0;
        for (int i = 0; i < W; i++) model_line[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk_ctrl);
        #1 rst = 1'b0;
        @(posedge clk_ctrl); #1;
        check_eq("rst_ready", mem_req_ready, 1'b1);
        check_eq("rst_tvalid", tvalid, 1'b0);
        check_eq("rst_tdata", tdata, 32'h0);
        check_eq("rst_tkeep", tkeep, 4'h0);
        check_eq("rst_tlast", tlast, 1'b0);
        check_eq("rst_mdr", mem_data_ready, 1'b0);
        check_eq("rst_stray", stray_wr, 1'b0);
        check_eq("rst_tmo", fill_timeout, 1'b0);
        check_line("rst_line");

        // Directed refill, words returned in reverse order
        tr_mode = 0;
        run_packet(32'h0002_A04C, 1'b0, '0, "refill");
        for (int i = W - 1; i >= 0; i--) push_resp(i, 32'hA0 + 32'(i), 1'b1);
        respond("refill");

        // Writeback with TREADY toggling; the refill line must stay untouched
        tr_mode = 1;
        wl = random_line();
        run_packet($urandom, 1'b1, wl, "wb");
        check_line("wb_hold_line");

        // Duplicate word 3 and a strobe-less write
        tr_mode = 2;
        run_packet($urandom, 1'b0, '0, "dup");
        push_resp(3, $urandom, 1'b1);
        for (int i = 0; i < 3; i++) push_resp(i, $urandom, 1'b1);
        push_resp(5, 32'hDEAD_BEEF, 1'b0);
        push_resp(3, $urandom, 1'b1);
        for (int i = 4; i < W; i++) push_resp(i, $urandom, 1'b1);
        respond("dup");

        // Stray write while idle
        @(posedge clk_ctrl); #1;
        mem_valid = 1'b1; mem_wstrb = 1'b1; mem_addr = 32'h3; mem_wdata = $urandom;
        @(posedge clk_ctrl); #1;
        mem_valid = 1'b0; mem_wstrb = 1'b0;
        check_eq("stray_pulse", stray_wr, 1'b1);
        check_eq("stray_ready", mem_req_ready, 1'b1);
        check_eq("stray_tvalid", tvalid, 1'b0);
        @(posedge clk_ctrl); #1;
        check_eq("stray_end", stray_wr, 1'b0);
        check_line("stray_line");

        // Timeout with no response, then re-issue and normal completion
        t0 = tmo_cnt;
        run_packet($urandom, 1'b0, '0, "tmo");
        hit = -1;
        for (int k = 0; k <= TMO + 2 && hit < 0; k++) begin
            @(negedge clk_ctrl); #1;
            if (fill_timeout) begin
                hit = k;
                clear_got();
            end
        end
        check_eq("tmo_cycle", 64'(hit), 64'(TMO));
        collect_packet("tmo_retry");
        check_eq("tmo_count", tmo_cnt - t0, 1);
        for (int i = W - 1; i >= 0; i--) push_resp(i, $urandom, 1'b1);
        respond("tmo_fill");

        // Reset while beat 5 of a writeback is on the bus
        tr_mode = 0;
        clear_got();
        send_req($urandom, 1'b1, random_line());
        for (int n = 0; n < 100 && got_data_q.size() < 4; n++) begin
            @(negedge clk_ctrl); #1;
        end
        check_eq("mid_rst_beats", got_data_q.size(), 4);
        @(posedge clk_ctrl); #1;
        rst = 1'b1;
        #1 check_eq("mid_rst_tvalid", tvalid, 1'b0);
        for (int i = 0; i < W; i++) model_line[i] = 32'h0;
        repeat (2) @(posedge clk_ctrl);
        #1 rst = 1'b0;
        @(posedge clk_ctrl); #1;
        check_eq("post_rst_ready", mem_req_ready, 1'b1);
        check_eq("post_rst_tvalid", tvalid, 1'b0);
        check_line("post_rst_line");
        run_packet($urandom, 1'b0, '0, "post_rst");
        push_random_order();
        respond("post_rst");

        // Random traffic
        tr_mode = 2;
        for (int it = 0; it < 6; it++) begin
            bit wb = 1'($urandom_range(0, 1));
            wl = random_line();
            run_packet($urandom, wb, wl, $sformatf("rnd%0d", it));
            if (wb) begin
                check_line($sformatf("rnd%0d_hold", it));
            end else begin
                push_random_order();
                respond($sformatf("rnd%0d", it));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
